// File: rtl/conv_accum_requant.sv
// Per-channel conv accumulator: sums inner-dot partials plus bias over
// ch_num beats, then rounds, shifts, saturates to int8 and applies ReLU.
module conv_accum_requant #(
    parameter int SUM_WIDTH = 20,
    parameter int ACC_WIDTH = 30
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [SUM_WIDTH-1:0] in_sum,
    input  logic        [7:0]           cfg_ch_num,
    input  logic signed [15:0]          cfg_bias,
    input  logic        [3:0]           cfg_shift,
    input  logic                        cfg_relu,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [7:0]           out_data,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    localparam logic signed [ACC_WIDTH:0] MAXV = 127;
    localparam logic signed [ACC_WIDTH:0] MINV = -128;

    state_t                      state;
    logic signed [ACC_WIDTH-1:0] acc;
    logic        [8:0]           cnt;
    logic        [7:0]           ch_q;
    logic        [3:0]           sh_q;
    logic                        relu_q;

    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] s;
    logic signed [ACC_WIDTH:0]   rnd;
    logic signed [ACC_WIDTH:0]   r;
    logic signed [7:0]           q;
    logic        [8:0]           cnt_nxt;
    logic        [8:0]           tgt;
    logic        [7:0]           ch;
    logic        [3:0]           sh;
    logic                        relu;
    logic                        first;
    logic                        take;
    logic                        last;

    assign first    = (state == IDLE);
    assign in_ready = (state != OUT);
    assign busy     = (state != IDLE);
    assign take     = in_valid && in_ready;

    // On the first beat the live cfg is used, since it is latched that edge.
    always_comb begin
        ch      = first ? cfg_ch_num : ch_q;
        sh      = first ? cfg_shift  : sh_q;
        relu    = first ? cfg_relu   : relu_q;
        base    = first ? ACC_WIDTH'(cfg_bias) : acc;
        s       = base + ACC_WIDTH'(in_sum);
        tgt     = (ch == 8'd0) ? 9'd256 : {1'b0, ch};
        cnt_nxt = first ? 9'd1 : cnt + 9'd1;
        last    = (cnt_nxt == tgt);
        rnd     = '0;
        if (sh != 4'd0)
            rnd = (ACC_WIDTH+1)'(1) << (sh - 4'd1);
        r = ((ACC_WIDTH+1)'(s) + rnd) >>> sh;
        if (r > MAXV)
            q = 8'sd127;
        else if (r < MINV)
            q = -8'sd128;
        else
            q = r[7:0];
        if (relu && q[7])
            q = 8'sd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            ch_q      <= '0;
            sh_q      <= '0;
            relu_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (take) begin
                        if (first) begin
                            ch_q   <= cfg_ch_num;
                            sh_q   <= cfg_shift;
                            relu_q <= cfg_relu;
                        end
                        if (last) begin
                            out_data  <= q;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            cnt       <= '0;
                            state     <= OUT;
                        end else begin
                            acc   <= s;
                            cnt   <= cnt_nxt;
                            state <= ACCUM;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_accum_requant.sv
// Bench for conv_accum_requant: vector table plus hand-written corner
// sequences, with expected int8 results checked through a scoreboard queue.
module tb_conv_accum_requant;

    localparam int SW = 20;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [SW-1:0] in_sum = '0;
    logic        [7:0]    cfg_ch_num = '0;
    logic signed [15:0]   cfg_bias = '0;
    logic        [3:0]    cfg_shift = '0;
    logic                 cfg_relu = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [7:0]    out_data;
    logic                 busy;

    conv_accum_requant #(.SUM_WIDTH(SW), .ACC_WIDTH(30)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .cfg_ch_num (cfg_ch_num),
        .cfg_bias   (cfg_bias),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              nb;
        logic [7:0]      ch;
        logic signed [15:0] bias;
        logic [3:0]      sh;
        logic            relu;
        int              s0;
        int              s1;
        int              s2;
        int              exp;
    } vec_t;

    vec_t              vt[$];
    logic signed [7:0] sb[$];
    logic signed [7:0] e;
    int                nvec = 0;
    int                nerr = 0;

    task automatic chk(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Output monitor: a handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'(out_data), 32'sd999);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e));
            end
        end
    end

    task automatic beat(input int v);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'sd1);
        in_valid = 1'b1;
        in_sum   = SW'(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 32'(sb.size()), 32'sd0);
            sb.delete();
        end
    endtask

    task automatic setcfg(input logic [7:0] ch, input logic signed [15:0] b,
                          input logic [3:0] sh, input logic rl);
        cfg_ch_num = ch;
        cfg_bias   = b;
        cfg_shift  = sh;
        cfg_relu   = rl;
    endtask

    task automatic frame(input vec_t v);
        int s[3];
        s = '{v.s0, v.s1, v.s2};
        setcfg(v.ch, v.bias, v.sh, v.relu);
        sb.push_back(8'(v.exp));
        for (int i = 0; i < v.nb; i++)
            beat(s[i]);
        drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vt.push_back('{3, 8'd3, 16'sd10,   4'd2,  1'b0, 5, 6, 7, 7});
        vt.push_back('{1, 8'd1, 16'sd0,    4'd1,  1'b0, -3, 0, 0, -1});
        vt.push_back('{1, 8'd1, 16'sd0,    4'd1,  1'b0, -1, 0, 0, 0});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd0,  1'b0, 200, 100, 0, 127});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd0,  1'b0, -200, -100, 0, -128});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd0,  1'b1, -200, -100, 0, 0});
        vt.push_back('{2, 8'd2, -16'sd5,   4'd0,  1'b1, 30, 20, 0, 45});
        vt.push_back('{1, 8'd1, -16'sd1000, 4'd3, 1'b0, 1500, 0, 0, 63});
        vt.push_back('{3, 8'd3, 16'sd0,    4'd0,  1'b0, 127, 1, -1, 127});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd0,  1'b0, 128, 0, 0, 127});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd0,  1'b0, -128, 0, 0, -128});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd0,  1'b0, -129, 0, 0, -128});
        vt.push_back('{1, 8'd1, 16'sd0,    4'd15, 1'b0, 16384, 0, 0, 1});
        vt.push_back('{1, 8'd1, 16'sd0,    4'd15, 1'b0, 16383, 0, 0, 0});
        vt.push_back('{1, 8'd1, 16'sd0,    4'd2,  1'b0, -6, 0, 0, -1});
        vt.push_back('{1, 8'd1, 16'sd0,    4'd2,  1'b0, -7, 0, 0, -2});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd14, 1'b0, 524287, 524287, 0, 64});
        vt.push_back('{2, 8'd2, 16'sd0,    4'd12, 1'b0, 524287, -524288, 0, 0});

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'sd0);
        chk("rst_out_data", 32'(out_data), 32'sd0);
        chk("rst_busy", 32'(busy), 32'sd0);
        rst_n = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'sd1);

        // Single beat, latency and busy
        setcfg(8'd1, 16'sd0, 4'd0, 1'b0);
        sb.push_back(8'sd100);
        beat(100);
        chk("single_valid", 32'(out_valid), 32'sd1);
        chk("single_busy", 32'(busy), 32'sd1);
        drain();
        chk("single_busy_after", 32'(busy), 32'sd0);
        chk("single_ready_after", 32'(in_ready), 32'sd1);

        foreach (vt[i])
            frame(vt[i]);

        // ch_num=0 means 256 beats
        setcfg(8'd0, 16'sd0, 4'd10, 1'b0);
        sb.push_back(8'sd127);
        for (int i = 0; i < 256; i++) begin
            beat(1000);
            if (i == 254)
                chk("b256_no_early_out", 32'(out_valid), 32'sd0);
        end
        drain();

        setcfg(8'd0, 16'sd0, 4'd0, 1'b0);
        sb.push_back(8'sd77);
        for (int i = 0; i < 256; i++)
            beat(i == 255 ? 77 : 0);
        drain();

        // Backpressure
        out_ready = 1'b0;
        setcfg(8'd1, 16'sd0, 4'd0, 1'b0);
        sb.push_back(8'sd42);
        beat(42);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'sd1);
            chk("bp_data", 32'(out_data), 32'sd42);
            chk("bp_in_ready", 32'(in_ready), 32'sd0);
            in_valid = 1'b1;
            in_sum   = SW'(99);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_after", 32'(out_valid), 32'sd0);
        chk("bp_in_ready_after", 32'(in_ready), 32'sd1);
        chk("bp_busy_after", 32'(busy), 32'sd0);
        chk("bp_sb_empty", 32'(sb.size()), 32'sd0);

        // Reset mid-frame
        setcfg(8'd4, 16'sd0, 4'd0, 1'b0);
        beat(5);
        beat(6);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", 32'(busy), 32'sd0);
        chk("midrst_in_ready", 32'(in_ready), 32'sd1);
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_out", 32'(out_valid), 32'sd0);
            @(posedge clk); #1;
        end
        setcfg(8'd1, 16'sd0, 4'd0, 1'b0);
        sb.push_back(8'sd5);
        beat(5);
        drain();

        // Config changes mid-frame are ignored
        setcfg(8'd2, 16'sd0, 4'd0, 1'b0);
        sb.push_back(-8'sd20);
        beat(40);
        setcfg(8'd5, 16'sd100, 4'd3, 1'b1);
        beat(-60);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("final_sb_empty", 32'(sb.size()), 32'sd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/conv_accum_requant.md
CONV_ACCUM_REQUANT -- requirements
Module: conv_accum_requant

Interface
REQ-001 The module SHALL have parameter SUM_WIDTH, default 20: width of the signed 3x3 inner-dot sum consumed per beat.
REQ-002 The module SHALL have parameter ACC_WIDTH, default 30: internal accumulator width; it SHALL be at least SUM_WIDTH+9, so 256 beats plus bias cannot overflow.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  in_sum is valid this cycle.
REQ-006 in_ready  output  1  the module accepts in_sum this cycle.
REQ-007 in_sum  input  SUM_WIDTH signed  per-channel partial sum from the inner-dot stage.
REQ-008 cfg_ch_num  input  8  beats per output; 0 means 256.
REQ-009 cfg_bias  input  16 signed  bias added once per output.
REQ-010 cfg_shift  input  4  arithmetic right-shift amount, 0..15.
REQ-011 cfg_relu  input  1  when 1, negative results clamp to 0.
REQ-012 out_valid  output  1  out_data is valid.
REQ-013 out_ready  input  1  the consumer accepts out_data.
REQ-014 out_data  output  8 signed  requantized int8 result.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The module SHALL implement three states:
- IDLE: no frame in progress.
- ACCUM: accumulating beats.
- OUT: holding a result for the consumer.
REQ-017 A beat SHALL be accepted only on a cycle where in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM and 0 in OUT; in_valid in OUT SHALL be ignored, with no state change.
REQ-019 On the first accepted beat in IDLE, the module SHALL latch cfg_ch_num, cfg_bias, cfg_shift and cfg_relu; cfg_* changes during a frame SHALL have no effect.
REQ-020 On the first beat, the accumulator SHALL load sign-extended cfg_bias plus sign-extended in_sum.
REQ-021 Each later beat SHALL add sign-extended in_sum to the accumulator.
REQ-022 A beat counter SHALL count accepted beats; the beat that makes the count equal to the latched ch_num (256 if 0) is the final beat.
REQ-023 State transitions SHALL be:
- IDLE -> ACCUM on a non-final first beat.
- IDLE -> OUT when the first beat is final (ch_num=1).
- ACCUM -> OUT on the final beat.
- OUT -> IDLE on out_valid and out_ready.
REQ-024 On the final beat, the module SHALL form S = accumulator + in_sum at full ACC_WIDTH precision.
REQ-025 The module SHALL round S: if shift>0, R = (S + 2^(shift-1)) >>> shift; if shift=0, R = S.
REQ-026 R SHALL saturate to the range [-128, 127].
REQ-027 If the latched relu bit is 1, negative saturated values SHALL be replaced by 0.
REQ-028 The result SHALL be registered into out_data, with out_valid=1 on the cycle after the final beat is accepted (latency 1).
REQ-029 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-030 out_data SHALL be undefined-free: when out_valid=0 it holds its last value (0 after reset).
REQ-031 No overlap SHALL occur: a new frame may start only in IDLE, at the earliest the cycle after the output handshake.

Reset
REQ-032 While rst_n=0 at a rising edge, the module SHALL set:
- state=IDLE
- accumulator=0
- beat counter=0
- all latched cfg fields=0
- out_valid=0
- out_data=0
- busy=0
REQ-033 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-034 Reset asserted mid-ACCUM or mid-OUT SHALL discard the partial frame or pending result; no output for it SHALL ever appear.

Verification
REQ-035 Single beat: ch_num=1, bias=0, shift=0, relu=0, in_sum=100 -> out_valid next cycle, out_data=100, busy 1 then 0 after handshake.
REQ-036 Multi-beat with bias and rounding: ch_num=3, bias=10, shift=2, sums 5,6,7 -> S=28, out_data=(28+2)>>>2=7; sums -3 with ch_num=1, bias=0, shift=1 -> out_data=-1; sum -1 -> out_data=0.
REQ-037 Saturation and ReLU:
- ch_num=2, shift=0, sums 200,100 -> 127.
- sums -200,-100 -> -128.
- same with relu=1 -> 0.
- ch_num=0 with 256 beats of 1000, shift=10 -> (256000+512)>>>10=250 -> 127.
REQ-038 Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> handshake, next cycle state IDLE, in_ready=1.
REQ-039 Reset mid-frame: ch_num=4, accept 2 beats, pulse rst_n=0 for 1 cycle -> out_valid stays 0; a new frame ch_num=1, sum=5, shift=0, bias=0 -> out_data=5.
REQ-040 Config isolation: change cfg_shift and cfg_bias after the first beat of a ch_num=2 frame -> result uses the values latched on the first beat.
